// File: rtl/byte_serializer.sv
// Parallel-to-serial stage with a one-entry holding register, feeding the serial sequence detector.
// Optional build macro SERIALIZER_LSB_FIRST_EN sends bit 0 first; default sends bit WIDTH-1 first.
module byte_serializer #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             out,
    output logic             frame_start,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               transfer;
    logic [WIDTH-1:0]   sh_next;
    logic               cur_bit;

`ifdef SERIALIZER_LSB_FIRST_EN
    assign sh_next = {1'b0, sh_q[WIDTH-1:1]};
    assign cur_bit = sh_q[0];
`else
    assign sh_next = {sh_q[WIDTH-2:0], 1'b0};
    assign cur_bit = sh_q[WIDTH-1];
`endif

    assign data_ready = ~hold_full_q & ~rst;
    assign transfer   = data_valid & data_ready;

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    sh_d    = data_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    // Held character wins over a new one; the two cannot coincide anyway.
                    if (hold_full_q) begin
                        sh_d        = hold_q;
                        hold_full_d = 1'b0;
                        cnt_d       = '0;
                    end else if (transfer) begin
                        sh_d  = data_in;
                        cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    sh_d  = sh_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (transfer) begin
                        hold_d      = data_in;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
        end
    end

    assign busy        = (state_q == SHIFT);
    assign out         = busy ? cur_bit : IDLE_BIT;
    assign frame_start = busy && (cnt_q == '0);

endmodule

// File: tb/tb_byte_serializer.sv
// Directed self-checking bench for byte_serializer; expected bit order follows SERIALIZER_LSB_FIRST_EN.
module tb_byte_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       out;
    logic       frame_start;
    logic       busy;

    int tests_run = 0;
    int tests_failed = 0;

    byte_serializer #(.WIDTH(8), .IDLE_BIT(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .out(out),
        .frame_start(frame_start),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Transmit-order sequence of a character: element [7] goes out first.
    function automatic logic [7:0] seq_of(input logic [7:0] c);
        logic [7:0] r;
`ifdef SERIALIZER_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[7-i] = c[i];
`else
        r = c;
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; data_valid = 1'b1; data_in = 8'hA5;
        for (int c = 0; c < 2; c++) begin
            tick();
            tests_run++;
            if (out !== 1'b1 || busy !== 1'b0 || frame_start !== 1'b0 || data_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold cyc%0d: out=%b busy=%b fs=%b rdy=%b, want 1 0 0 0",
                         c, out, busy, frame_start, data_ready);
            end
        end
        rst = 1'b0; data_valid = 1'b0;
        #1;
        tests_run++;
        if (data_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready_after: data_ready=%b, want 1", data_ready);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            tests_run++;
            if (out !== 1'b1 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_no_emit cyc%0d: out=%b busy=%b, want 1 0", c, out, busy);
            end
        end
    endtask

    task automatic check_idle(input string name);
        tests_run++;
        if (out !== 1'b1 || busy !== 1'b0 || frame_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_idle: out=%b busy=%b fs=%b, want 1 0 0", name, out, busy, frame_start);
        end
    endtask

    task automatic test_single();
        logic [7:0] s;
        s = seq_of(8'h56);
        data_in = 8'h56; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (out !== s[7-i] || frame_start !== (i == 0) || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL single bit%0d: out=%b fs=%b busy=%b, want %b %b 1",
                         i, out, frame_start, busy, s[7-i], (i == 0));
            end
            tick();
        end
        check_idle("single");
    endtask

    task automatic test_back_to_back();
        logic [15:0] s;
        logic        exp_rdy;
        s = {seq_of(8'h56), seq_of(8'h76)};
        data_in = 8'h56; data_valid = 1'b1;
        tick();
        data_in = 8'h76;
        for (int k = 0; k < 16; k++) begin
            exp_rdy = (k == 0) || (k >= 8);
            tests_run++;
            if (out !== s[15-k] || frame_start !== (k == 0 || k == 8) || busy !== 1'b1
                || data_ready !== exp_rdy) begin
                tests_failed++;
                $display("FAIL b2b bit%0d: out=%b fs=%b busy=%b rdy=%b, want %b %b 1 %b",
                         k, out, frame_start, busy, data_ready, s[15-k], (k == 0 || k == 8), exp_rdy);
            end
            tick();
            data_valid = 1'b0;
        end
        check_idle("b2b");
    endtask

    task automatic test_backpressure();
        logic [7:0]  q[3];
        logic [23:0] s;
        int          idx;
        int          acc_k[3];
        q[0] = 8'h41; q[1] = 8'h42; q[2] = 8'h43;
        s = {seq_of(8'h41), seq_of(8'h42), seq_of(8'h43)};
        acc_k[1] = -1; acc_k[2] = -1;
        data_in = q[0]; data_valid = 1'b1;
        tick();
        idx = 1;
        for (int k = 0; k < 24; k++) begin
            tests_run++;
            if (out !== s[23-k] || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp bit%0d: out=%b busy=%b, want %b 1", k, out, busy, s[23-k]);
            end
            if (idx < 3) begin
                data_in = q[idx]; data_valid = 1'b1;
                if (data_ready) acc_k[idx] = k;
            end else begin
                data_valid = 1'b0;
            end
            tick();
            if (idx < 3 && acc_k[idx] == k) idx++;
        end
        data_valid = 1'b0;
        tests_run++;
        if (acc_k[1] !== 0 || acc_k[2] !== 8) begin
            tests_failed++;
            $display("FAIL bp_accept_cycle: 0x42 at %0d 0x43 at %0d, want 0 8", acc_k[1], acc_k[2]);
        end
        check_idle("bp");
    endtask

    task automatic test_reset_mid();
        logic [7:0] s;
        data_in = 8'h56; data_valid = 1'b1;
        tick();
        data_in = 8'h76;
        tick();
        data_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        tests_run++;
        if (data_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_ready: data_ready=%b, want 0", data_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        tests_run++;
        if (data_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_ready_after: data_ready=%b, want 1", data_ready);
        end
        for (int c = 0; c < 12; c++) begin
            check_idle("midrst");
            tick();
        end
        s = seq_of(8'h0F);
        data_in = 8'h0F; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (out !== s[7-i] || frame_start !== (i == 0) || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL midrst_0f bit%0d: out=%b fs=%b busy=%b, want %b %b 1",
                         i, out, frame_start, busy, s[7-i], (i == 0));
            end
            tick();
        end
        check_idle("midrst_0f");
    endtask

    initial begin
        test_reset();
        test_single();
        tick();
        test_back_to_back();
        tick();
        test_backpressure();
        tick();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
